// File: rtl/plru_state_ctrl.sv
// plru_state_ctrl
//   Per-set tree-PLRU replacement state for the data cache. Each set keeps
//   NUM_WAYS-1 age bits arranged as a binary tree (node 0 = root, children of
//   node n are 2n+1 / 2n+2, bit 0 = LRU on the left). A hit touches the
//   accessed way; a refill asks for a victim, which is decoded from the tree
//   while the traversed path is inverted.
//
// Ports
//   clk_i, rst_i     clock, synchronous active-high reset
//   flush_i          pulse: re-initialise every set (ignored while sweeping)
//   init_done_o      state array initialised, requests accepted
//   touch_*_i        hit access: set and way to mark most-recently-used
//   victim_req_i     victim request for victim_set_i
//   victim_ready_o   request accepted this cycle (same as init_done_o)
//   victim_valid_o   one-cycle response pulse, one cycle after acceptance
//   victim_way_o     selected victim, held until the next response
module plru_state_ctrl #(
    parameter int unsigned NUM_WAYS = 4,
    parameter int unsigned NUM_SETS = 64
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        flush_i,
    output logic                        init_done_o,
    input  logic                        touch_valid_i,
    input  logic [$clog2(NUM_SETS)-1:0] touch_set_i,
    input  logic [$clog2(NUM_WAYS)-1:0] touch_way_i,
    input  logic                        victim_req_i,
    input  logic [$clog2(NUM_SETS)-1:0] victim_set_i,
    output logic                        victim_ready_o,
    output logic                        victim_valid_o,
    output logic [$clog2(NUM_WAYS)-1:0] victim_way_o
);

    localparam int unsigned AGE_WIDTH = NUM_WAYS - 1;
    localparam int unsigned WAY_WIDTH = $clog2(NUM_WAYS);
    localparam int unsigned SET_WIDTH = $clog2(NUM_SETS);

    typedef enum logic {
        INIT,
        READY
    } state_t;

    state_t               state_q, state_d;
    logic [SET_WIDTH-1:0] cnt_q, cnt_d;
    logic [AGE_WIDTH-1:0] age_q [NUM_SETS];

    logic                 touch_en;
    logic                 victim_en;
    logic [AGE_WIDTH-1:0] touch_bits;
    logic [AGE_WIDTH-1:0] victim_base;
    logic [AGE_WIDTH-1:0] victim_bits;
    logic [WAY_WIDTH-1:0] victim_way;

    // Walk root-to-leaf along the way bits (MSB first, 0 = left) and point
    // every visited node away from the touched way.
    function automatic logic [AGE_WIDTH-1:0] touch_encode(
        input logic [AGE_WIDTH-1:0] bits,
        input logic [WAY_WIDTH-1:0] way
    );
        logic [AGE_WIDTH-1:0] res;
        logic [AGE_WIDTH-1:0] mask;
        logic [WAY_WIDTH-1:0] w;
        logic                 dir;
        int unsigned          node;
        res  = bits;
        w    = way;
        node = 0;
        for (int unsigned l = 0; l < WAY_WIDTH; l++) begin
            dir  = w[WAY_WIDTH-1];
            mask = AGE_WIDTH'(1) << node;
            if (dir) res = res & ~mask;
            else     res = res | mask;
            node = 2 * node + 1 + 32'(dir);
            w    = w << 1;
        end
        return res;
    endfunction

    // Follow the node bits from the root; the leaf reached is the victim and
    // each visited node is flipped.
    function automatic logic [AGE_WIDTH-1:0] victim_decode(
        input  logic [AGE_WIDTH-1:0] bits,
        output logic [WAY_WIDTH-1:0] way
    );
        logic [AGE_WIDTH-1:0] res;
        logic [AGE_WIDTH-1:0] mask;
        logic                 dir;
        int unsigned          node;
        res  = bits;
        node = 0;
        for (int unsigned l = 0; l < WAY_WIDTH; l++) begin
            mask = AGE_WIDTH'(1) << node;
            dir  = |(res & mask);
            res  = res ^ mask;
            node = 2 * node + 1 + 32'(dir);
        end
        way = WAY_WIDTH'(node - AGE_WIDTH);
        return res;
    endfunction

    assign init_done_o    = (state_q == READY);
    assign victim_ready_o = (state_q == READY);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            INIT: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == SET_WIDTH'(NUM_SETS - 1)) begin
                    state_d = READY;
                    cnt_d   = '0;
                end
            end
            READY: begin
                if (flush_i) begin
                    state_d = INIT;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = INIT;
                cnt_d   = '0;
            end
        endcase
    end

    // A same-set touch is folded in before the victim decode so that one
    // write-back carries both updates.
    always_comb begin
        touch_en    = (state_q == READY) && !flush_i && touch_valid_i;
        victim_en   = (state_q == READY) && !flush_i && victim_req_i;
        touch_bits  = touch_encode(age_q[touch_set_i], touch_way_i);
        victim_base = (touch_en && (touch_set_i == victim_set_i)) ? touch_bits
                                                                  : age_q[victim_set_i];
        victim_way  = '0;
        victim_bits = victim_decode(victim_base, victim_way);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            victim_valid_o <= 1'b0;
            victim_way_o   <= '0;
        end else begin
            victim_valid_o <= victim_en;
            if (victim_en) victim_way_o <= victim_way;
        end
    end

    // Array has no reset; the INIT sweep defines its contents.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            if (state_q == INIT) begin
                age_q[cnt_q] <= '0;
            end else begin
                if (touch_en)  age_q[touch_set_i]  <= touch_bits;
                if (victim_en) age_q[victim_set_i] <= victim_bits;
            end
        end
    end

endmodule

// File: tb/tb_plru_state_ctrl.sv
// Self-checking bench for plru_state_ctrl: a 4-way/64-set instance checked
// every cycle against a tree model, plus an 8-way instance for the longer
// victim sequence.
module tb_plru_state_ctrl;

    localparam int NW = 4;
    localparam int NS = 64;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, flush, touch_valid, victim_req;
    logic [5:0] touch_set, victim_set;
    logic [1:0] touch_way;
    logic       init_done, victim_ready, victim_valid;
    logic [1:0] victim_way;

    logic       init8, rdy8, val8, vreq8;
    logic [5:0] vset8;
    logic [2:0] way8;

    int errors = 0;
    int checks = 0;
    bit checking = 0;

    plru_state_ctrl #(.NUM_WAYS(4), .NUM_SETS(64)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .flush_i       (flush),
        .init_done_o   (init_done),
        .touch_valid_i (touch_valid),
        .touch_set_i   (touch_set),
        .touch_way_i   (touch_way),
        .victim_req_i  (victim_req),
        .victim_set_i  (victim_set),
        .victim_ready_o(victim_ready),
        .victim_valid_o(victim_valid),
        .victim_way_o  (victim_way)
    );

    plru_state_ctrl #(.NUM_WAYS(8), .NUM_SETS(64)) dut8 (
        .clk_i         (clk),
        .rst_i         (rst),
        .flush_i       (1'b0),
        .init_done_o   (init8),
        .touch_valid_i (1'b0),
        .touch_set_i   (6'd0),
        .touch_way_i   (3'd0),
        .victim_req_i  (vreq8),
        .victim_set_i  (vset8),
        .victim_ready_o(rdy8),
        .victim_valid_o(val8),
        .victim_way_o  (way8)
    );

    // Model state: tree node bits per set, readiness and sweep progress.
    bit mtree [NS][NW-1];
    bit m_ready;
    int m_cnt;
    bit m_valid;
    int m_way;

    int b2b_exp [5] = '{0, 2, 1, 3, 0};
    int seq8    [8] = '{0, 4, 2, 6, 1, 5, 3, 7};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Range-halving walk: each level splits the candidate ways in two.
    task m_touch(input int s, input int w);
        int n, lo, span;
        n = 0; lo = 0; span = NW;
        while (span > 1) begin
            span = span / 2;
            if (w >= lo + span) begin
                mtree[s][n] = 1'b0;
                lo = lo + span;
                n  = 2 * n + 2;
            end else begin
                mtree[s][n] = 1'b1;
                n = 2 * n + 1;
            end
        end
    endtask

    task m_victim(input int s, output int w);
        int n, lo, span;
        bit b;
        n = 0; lo = 0; span = NW;
        while (span > 1) begin
            span = span / 2;
            b = mtree[s][n];
            mtree[s][n] = ~b;
            if (b) begin
                lo = lo + span;
                n  = 2 * n + 2;
            end else begin
                n = 2 * n + 1;
            end
        end
        w = lo;
    endtask

    always @(posedge clk) begin
        if (rst) begin
            m_ready = 0; m_cnt = 0; m_valid = 0; m_way = 0;
        end else begin
            m_valid = 0;
            if (!m_ready) begin
                m_cnt++;
                if (m_cnt == NS) begin
                    m_ready = 1;
                    m_cnt   = 0;
                    for (int s = 0; s < NS; s++)
                        for (int k = 0; k < NW - 1; k++) mtree[s][k] = 1'b0;
                end
            end else if (flush) begin
                m_ready = 0;
                m_cnt   = 0;
            end else begin
                if (touch_valid) m_touch(int'(touch_set), int'(touch_way));
                if (victim_req) begin
                    m_victim(int'(victim_set), m_way);
                    m_valid = 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            chk("init_done", init_done, m_ready);
            chk("victim_ready", victim_ready, m_ready);
            chk("victim_valid", victim_valid, m_valid);
            chk("victim_way", victim_way, m_way);
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_init(input string name);
        int n;
        n = 0;
        while (init_done !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        chk(name, n, 64);
    endtask

    task automatic clear_inputs();
        flush = 0; touch_valid = 0; victim_req = 0;
    endtask

    initial begin
        int n;
        rst = 1; flush = 0; touch_valid = 0; touch_set = '0; touch_way = '0;
        victim_req = 0; victim_set = '0; vreq8 = 0; vset8 = '0;
        @(negedge clk);
        tick();
        checking = 1;
        chk("reset_init_done", init_done, 0);
        chk("reset_valid", victim_valid, 0);
        chk("reset_way", victim_way, 0);
        tick();
        rst = 0;
        wait_init("init_len");

        victim_req = 1; victim_set = 6'd17;
        tick();
        clear_inputs();
        chk("first_valid", victim_valid, 1);
        chk("first_way", victim_way, 0);

        victim_req = 1; victim_set = 6'd3;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("b2b_way", victim_way, b2b_exp[i]);
        end
        clear_inputs();
        chk("set3_bits", {mtree[3][0], mtree[3][1], mtree[3][2]}, 3'b110);

        touch_valid = 1; touch_set = 6'd5; touch_way = 2'd0;
        tick();
        clear_inputs();
        victim_req = 1; victim_set = 6'd5;
        tick();
        clear_inputs();
        chk("touch0_victim", victim_way, 2);
        touch_valid = 1; touch_set = 6'd5; touch_way = 2'd2;
        tick();
        clear_inputs();
        victim_req = 1; victim_set = 6'd5;
        tick();
        clear_inputs();
        chk("touch2_victim", victim_way, 1);

        touch_valid = 1; touch_set = 6'd7; touch_way = 2'd0;
        victim_req = 1; victim_set = 6'd7;
        tick();
        clear_inputs();
        chk("same_set_way", victim_way, 2);
        chk("set7_bits", {mtree[7][0], mtree[7][1], mtree[7][2]}, 3'b011);

        touch_valid = 1; touch_set = 6'd8; touch_way = 2'd0;
        victim_req = 1; victim_set = 6'd9;
        tick();
        clear_inputs();
        chk("diff_set_way", victim_way, 0);
        chk("set8_bits", {mtree[8][0], mtree[8][1], mtree[8][2]}, 3'b110);

        for (int i = 0; i < 600; i++) begin
            touch_valid = 1'($urandom_range(0, 1));
            touch_set   = 6'($urandom_range(0, 7));
            touch_way   = 2'($urandom_range(0, 3));
            victim_req  = 1'($urandom_range(0, 1));
            victim_set  = 6'($urandom_range(0, 7));
            flush       = ($urandom_range(0, 149) == 0);
            tick();
        end
        clear_inputs();
        n = 0;
        while (init_done !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        chk("ready_after_random", init_done, 1);

        victim_req = 1; victim_set = 6'd2;
        tick();
        chk("pend_valid", victim_valid, 1);
        flush = 1; victim_req = 1; victim_set = 6'd4;
        touch_valid = 1; touch_set = 6'd4; touch_way = 2'd1;
        tick();
        clear_inputs();
        chk("flush_drop", victim_valid, 0);
        wait_init("flush_len");

        victim_req = 1;
        for (int s = 0; s < NS; s++) begin
            victim_set = 6'(s);
            tick();
            chk("post_flush_way", victim_way, 0);
        end
        clear_inputs();

        rst = 1;
        tick();
        rst = 0;
        repeat (30) tick();
        chk("mid_sweep_low", init_done, 0);
        rst = 1;
        tick();
        rst = 0;
        wait_init("rst_restart_len");

        chk("w8_ready", init8, 1);
        chk("w8_rdy", rdy8, 1);
        vreq8 = 1; vset8 = 6'd11;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("w8_valid", val8, 1);
            chk("w8_way", way8, seq8[i]);
        end
        vreq8 = 0;
        tick();
        chk("w8_pulse", val8, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
